// File: rtl/dds_quad_sweep.sv
// Quadrature DDS with register-programmed tuning word, phase offset and linear
// frequency sweep. Sine and cosine share a single quarter-wave ROM; quadrant
// mirroring and sign restoration happen in the pipeline stages that follow.
module dds_quad_sweep #(
   parameter int PHASE_W = 32,
   parameter int LUT_AW  = 10,
   parameter int OUT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ce,
   input  logic               we,
   input  logic [1:0]         waddr,
   input  logic [PHASE_W-1:0] data,
   output logic [OUT_W-1:0]   sine,
   output logic [OUT_W-1:0]   cose,
   output logic               out_valid,
   output logic [PHASE_W-1:0] ftw_cur
);

   localparam int  QA     = LUT_AW - 2;
   localparam int  QDEPTH = 1 << QA;
   localparam real TWO_PI = 6.283185307179586;
   localparam real AMP    = real'((1 << (OUT_W - 1)) - 1);

   // Quarter-wave table sampled at half-LSB offsets so that mirroring the
   // address (~a) lands exactly on the symmetric sample; no entry is zero.
   logic [OUT_W-2:0] rom_s [QDEPTH];
   for (genvar k = 0; k < QDEPTH; k++) begin : g_rom
      localparam real ANG = TWO_PI * (real'(k) + 0.5) / real'(2 ** LUT_AW);
      localparam int  VAL = $rtoi(AMP * $sin(ANG) + 0.5);
      assign rom_s[k] = VAL[OUT_W-2:0];
   end

   // Programming registers and phase state
   logic [PHASE_W-1:0] ftw_r;
   logic [PHASE_W-1:0] offset_r;
   logic [PHASE_W-1:0] step_r;
   logic               sweep_en_r;
   logic [PHASE_W-1:0] acc_r;

   // Pipeline registers
   logic [LUT_AW-1:0]  idx_r;
   logic [OUT_W-2:0]   rom_sin_r;
   logic [OUT_W-2:0]   rom_cos_r;
   logic               neg_sin_r;
   logic               neg_cos_r;
   logic [OUT_W-1:0]   sine_r;
   logic [OUT_W-1:0]   cose_r;
   logic [1:0]         vld_r;
   logic               out_valid_r;

   // Combinational helpers
   logic               wr_ftw_s;
   logic               wr_off_s;
   logic               wr_step_s;
   logic               wr_ctrl_s;
   logic               pclr_s;
   logic [PHASE_W-1:0] phase_s;
   logic [LUT_AW-1:0]  cidx_s;
   logic [QA-1:0]      sin_addr_s;
   logic [QA-1:0]      cos_addr_s;
   logic [OUT_W-1:0]   mag_sin_s;
   logic [OUT_W-1:0]   mag_cos_s;
   logic               unused_s;

   // Register write decode; phase clear is a one-cycle effect of the control write
   always_comb begin
      wr_ftw_s  = we && (waddr == 2'd0);
      wr_off_s  = we && (waddr == 2'd1);
      wr_step_s = we && (waddr == 2'd2);
      wr_ctrl_s = we && (waddr == 2'd3);
      pclr_s    = wr_ctrl_s && data[1];
   end

   // Address generation: offset phase, cosine a quarter turn ahead, mirror odd quadrants
   always_comb begin
      phase_s    = acc_r + offset_r;
      cidx_s     = idx_r + {2'b01, {QA{1'b0}}};
      sin_addr_s = idx_r[LUT_AW-2]  ? ~idx_r[QA-1:0]  : idx_r[QA-1:0];
      cos_addr_s = cidx_s[LUT_AW-2] ? ~cidx_s[QA-1:0] : cidx_s[QA-1:0];
      mag_sin_s  = {1'b0, rom_sin_r};
      mag_cos_s  = {1'b0, rom_cos_r};
      unused_s   = ^phase_s[PHASE_W-LUT_AW-1:0];
   end

   // Tuning word: explicit write beats the sweep increment
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ftw_r <= '0;
      end else if (wr_ftw_s) begin
         ftw_r <= data;
      end else if (ce && sweep_en_r) begin
         ftw_r <= ftw_r + step_r;
      end
   end

   // Offset, sweep step and sweep enable are plain write-only registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         offset_r   <= '0;
         step_r     <= '0;
         sweep_en_r <= 1'b0;
      end else begin
         if (wr_off_s)  offset_r   <= data;
         if (wr_step_s) step_r     <= data;
         if (wr_ctrl_s) sweep_en_r <= data[0];
      end
   end

   // Phase accumulator; phase clear overrides even when ce is low
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_r <= '0;
      end else if (pclr_s) begin
         acc_r <= '0;
      end else if (ce) begin
         acc_r <= acc_r + ftw_r;
      end
   end

   // Three-stage output pipeline: index, ROM read with sign, signed output
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_r       <= '0;
         rom_sin_r   <= '0;
         rom_cos_r   <= '0;
         neg_sin_r   <= 1'b0;
         neg_cos_r   <= 1'b0;
         sine_r      <= '0;
         cose_r      <= '0;
         vld_r       <= 2'b00;
         out_valid_r <= 1'b0;
      end else if (ce) begin
         idx_r       <= phase_s[PHASE_W-1 -: LUT_AW];
         rom_sin_r   <= rom_s[sin_addr_s];
         rom_cos_r   <= rom_s[cos_addr_s];
         neg_sin_r   <= idx_r[LUT_AW-1];
         neg_cos_r   <= cidx_s[LUT_AW-1];
         sine_r      <= neg_sin_r ? -mag_sin_s : mag_sin_s;
         cose_r      <= neg_cos_r ? -mag_cos_s : mag_cos_s;
         vld_r       <= {vld_r[0], 1'b1};
         out_valid_r <= vld_r[1];
      end
   end

   assign sine      = sine_r;
   assign cose      = cose_r;
   assign out_valid = out_valid_r;
   assign ftw_cur   = ftw_r;

endmodule

// File: tb/tb_dds_quad_sweep.sv
// Self-checking bench for dds_quad_sweep: scoreboard of hand-computed
// sine/cosine samples popped by a monitor, plus directed register checks.
module tb_dds_quad_sweep;

   logic        clk;
   logic        reset;
   logic        ce;
   logic        we;
   logic [1:0]  waddr;
   logic [31:0] data;
   logic [15:0] sine;
   logic [15:0] cose;
   logic        out_valid;
   logic [31:0] ftw_cur;

   typedef struct {
      logic signed [15:0] s;
      logic signed [15:0] c;
   } samp_t;

   samp_t sb_q[$];
   int    checks;
   int    failures;
   logic  mon_en;
   logic  mon_ce;

   // Quarter-turn tables for FTW = 0x40000000 (hand-computed from the ROM formula)
   logic signed [15:0] sq [4];
   logic signed [15:0] cq [4];

   dds_quad_sweep dut (
      .clk       (clk),
      .reset     (reset),
      .ce        (ce),
      .we        (we),
      .waddr     (waddr),
      .data      (data),
      .sine      (sine),
      .cose      (cose),
      .out_valid (out_valid),
      .ftw_cur   (ftw_cur)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_s(input string name, input logic signed [15:0] act, input logic signed [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input logic signed [15:0] s, input logic signed [15:0] c);
      samp_t e;
      e.s = s;
      e.c = c;
      sb_q.push_back(e);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      we    = 1'b1;
      waddr = a;
      data  = d;
      @(negedge clk);
      we    = 1'b0;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic drained(input string name);
      chk(name, sb_q.size(), 32'd0);
      sb_q.delete();
   endtask

   // Monitor: one new sample per ce edge once out_valid is up
   always @(posedge clk) begin
      samp_t e;
      mon_ce = ce;
      #1;
      if (mon_en && reset && mon_ce && out_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow: got sine=%0d cose=%0d expected no sample", $signed(sine), $signed(cose));
         end else begin
            e = sb_q.pop_front();
            chk_s("sb_sine", sine, e.s);
            chk_s("sb_cose", cose, e.c);
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int seq6 [8];
      sq = '{16'sd101, 16'sd32767, -16'sd101, -16'sd32767};
      cq = '{16'sd32767, -16'sd101, -16'sd32767, 16'sd101};
      seq6 = '{0, 1, 2, 3, 0, 1, 0, 1};
      checks = 0; failures = 0; mon_en = 1'b0;
      reset = 1'b0; ce = 1'b0; we = 1'b0; waddr = 2'd0; data = 32'd0;

      // Reset state
      #1;
      chk("rst_sine", {16'd0, sine}, 32'd0);
      chk("rst_cose", {16'd0, cose}, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_ftw", ftw_cur, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Basic quarter-rate tone with a ce 1,0,0,1 hold in the middle
      wr(2'd0, 32'h4000_0000);
      wr(2'd1, 32'h0);
      chk("ftw_loaded", ftw_cur, 32'h4000_0000);
      chk("valid_idle", {31'd0, out_valid}, 32'd0);
      for (int i = 0; i < 12; i++) push(sq[i % 4], cq[i % 4]);
      mon_en = 1'b1;
      ce = 1'b1;
      @(negedge clk); chk("valid_e1", {31'd0, out_valid}, 32'd0);
      @(negedge clk); chk("valid_e2", {31'd0, out_valid}, 32'd0);
      @(negedge clk); chk("valid_e3", {31'd0, out_valid}, 32'd1);
      repeat (7) @(negedge clk);
      ce = 1'b0;
      @(negedge clk);
      chk_s("hold1_sine", sine, -16'sd32767);
      chk_s("hold1_cose", cose, 16'sd101);
      @(negedge clk);
      chk_s("hold2_sine", sine, -16'sd32767);
      chk_s("hold2_cose", cose, 16'sd101);
      ce = 1'b1;
      repeat (4) @(negedge clk);
      ce = 1'b0;
      @(negedge clk);
      drained("sb_tone_drained");
      mon_en = 1'b0;

      // Quarter-turn phase offset: sine follows the former cosine
      reset_dut();
      wr(2'd0, 32'h4000_0000);
      wr(2'd1, 32'h4000_0000);
      for (int i = 0; i < 8; i++) push(cq[i % 4], sq[(i + 2) % 4]);
      mon_en = 1'b1;
      ce = 1'b1;
      repeat (10) @(negedge clk);
      ce = 1'b0;
      @(negedge clk);
      drained("sb_offset_drained");
      mon_en = 1'b0;

      // Linear sweep
      reset_dut();
      wr(2'd0, 32'h0);
      wr(2'd2, 32'h100);
      wr(2'd3, 32'h1);
      ce = 1'b1;
      repeat (10) @(negedge clk);
      ce = 1'b0;
      chk("sweep_10", ftw_cur, 32'h0000_0A00);
      wr(2'd3, 32'h0);
      @(negedge clk);
      chk("sweep_off_hold", ftw_cur, 32'h0000_0A00);
      ce = 1'b1;
      repeat (2) @(negedge clk);
      ce = 1'b0;
      chk("sweep_off_ce", ftw_cur, 32'h0000_0A00);
      wr(2'd3, 32'h1);
      ce = 1'b1;
      wr(2'd0, 32'h5);
      ce = 1'b0;
      chk("write_beats_sweep", ftw_cur, 32'h0000_0005);

      // Sweep wraps modulo 2^32
      wr(2'd2, 32'h1);
      wr(2'd0, 32'hFFFF_FFFF);
      ce = 1'b1;
      @(negedge clk); chk("wrap_0", ftw_cur, 32'h0000_0000);
      @(negedge clk); chk("wrap_1", ftw_cur, 32'h0000_0001);
      ce = 1'b0;

      // Phase clear mid-stream
      reset_dut();
      wr(2'd0, 32'h4000_0000);
      for (int i = 0; i < 8; i++) push(sq[seq6[i]], cq[seq6[i]]);
      mon_en = 1'b1;
      ce = 1'b1;
      repeat (5) @(negedge clk);
      wr(2'd3, 32'h2);
      repeat (3) @(negedge clk);
      chk_s("pclr_sine", sine, 16'sd101);
      chk_s("pclr_cose", cose, 16'sd32767);
      @(negedge clk);
      ce = 1'b0;
      chk("pclr_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      drained("sb_pclr_drained");
      mon_en = 1'b0;

      // Asynchronous reset mid-stream, then re-qualification
      ce = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      chk("arst_sine", {16'd0, sine}, 32'd0);
      chk("arst_cose", {16'd0, cose}, 32'd0);
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_ftw", ftw_cur, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk); chk("req_e1", {31'd0, out_valid}, 32'd0);
      @(negedge clk); chk("req_e2", {31'd0, out_valid}, 32'd0);
      @(negedge clk); chk("req_e3", {31'd0, out_valid}, 32'd1);
      chk_s("req_sine", sine, 16'sd101);
      chk_s("req_cose", cose, 16'sd32767);
      ce = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
